// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared constants for the IFU/LSU memory-port arbiter:
//   - FSM state encodings (IDLE, REQ, WAIT)
//   - requester identifiers (REQ_IF, REQ_LS), also used as one-hot grant bit
//     positions by arb_pick
//   - default parameter widths
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_CNT_W  = 32;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational 2-way picker for the memory arbiter.
// Configuration macro: MEM_ARB_RR_EN
//   defined   - round-robin: on a conflict the requester that is not
//               last_grant wins
//   undefined - fixed priority: LSU wins on a conflict; last_grant ignored
// Ports:
//   if_valid_i    IFU request valid
//   ls_valid_i    LSU request valid
//   last_grant_i  requester granted most recently (REQ_IF / REQ_LS)
//   grant_o       one-hot grant, bit REQ_IF = IFU, bit REQ_LS = LSU
// -----------------------------------------------------------------------------
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       if_valid_i,
    input  logic       ls_valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (if_valid_i && ls_valid_i) begin
`ifdef MEM_ARB_RR_EN
            if (last_grant_i == REQ_LS) begin
                grant_o[REQ_IF] = 1'b1;
            end else begin
                grant_o[REQ_LS] = 1'b1;
            end
`else
            grant_o[REQ_LS] = 1'b1;
`endif
        end else if (ls_valid_i) begin
            grant_o[REQ_LS] = 1'b1;
        end else if (if_valid_i) begin
            grant_o[REQ_IF] = 1'b1;
        end
    end

`ifndef MEM_ARB_RR_EN
    // Fixed priority never consults the grant history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between the instruction-fetch unit (IFU, read only)
// and the load/store unit (LSU). One transaction outstanding at a time:
//   IDLE : pick a requester (same-cycle ready), latch its request
//   REQ  : present latched request to memory until mem_req_ready
//   WAIT : forward mem_resp_valid/mem_rdata to the owner, back to IDLE
// Configuration macro: MEM_ARB_RR_EN (round-robin instead of LSU priority,
// implemented in arb_pick).
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_req_valid/ready, if_addr    IFU request channel
//   if_resp_valid, if_rdata        IFU response channel
//   ls_req_valid/ready, ls_addr,
//   ls_wen, ls_wdata, ls_wmask     LSU request channel
//   ls_resp_valid, ls_rdata        LSU response channel (rdata for reads)
//   mem_req_valid/ready, mem_addr,
//   mem_wen, mem_wdata, mem_wmask  memory request channel (latched fields)
//   mem_resp_valid, mem_rdata      memory response channel
//   busy                           state != IDLE
//   err_spurious                   sticky: response seen outside WAIT
//   if_grant_cnt, ls_grant_cnt     saturating grant counters
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy,
    output logic                err_spurious,
    output logic [CNT_W-1:0]    if_grant_cnt,
    output logic [CNT_W-1:0]    ls_grant_cnt
);

    localparam int MASK_W = DATA_W / 8;

    logic [1:0]        state_q, state_d;
    logic              owner_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [CNT_W-1:0]  if_cnt_q;
    logic [CNT_W-1:0]  ls_cnt_q;
    logic              err_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;

    logic [1:0]        pick;
    logic              grant_fire;
    logic              resp_fire;

    arb_pick u_pick (
        .if_valid_i   (if_req_valid),
        .ls_valid_i   (ls_req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (pick)
    );

    assign grant_fire = (state_q == IDLE) && (|pick);
    assign resp_fire  = (state_q == WAIT) && mem_resp_valid;

    // Readies are gated by rst_n so nothing is granted while reset is held,
    // even though the picker itself is purely combinational.
    assign if_req_ready  = grant_fire && pick[REQ_IF] && rst_n;
    assign ls_req_ready  = grant_fire && pick[REQ_LS] && rst_n;

    assign mem_req_valid = (state_q == REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    assign if_resp_valid = resp_fire && (owner_q == REQ_IF);
    assign ls_resp_valid = resp_fire && (owner_q == REQ_LS);

    // Pass the response through in the delivery cycle, otherwise hold the
    // last value routed to that requester.
    assign if_rdata = if_resp_valid ? mem_rdata : if_rdata_q;
    assign ls_rdata = ls_resp_valid ? mem_rdata : ls_rdata_q;

    assign busy         = (state_q != IDLE);
    assign err_spurious = err_q;
    assign if_grant_cnt = if_cnt_q;
    assign ls_grant_cnt = ls_cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant_fire)     state_d = REQ;
            REQ:  if (mem_req_ready)  state_d = WAIT;
            WAIT: if (mem_resp_valid) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= REQ_IF;
            last_grant_q <= REQ_IF;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            if_cnt_q     <= '0;
            ls_cnt_q     <= '0;
            err_q        <= 1'b0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
        end else begin
            state_q <= state_d;

            if (grant_fire) begin
                if (pick[REQ_LS]) begin
                    owner_q      <= REQ_LS;
                    last_grant_q <= REQ_LS;
                    addr_q       <= ls_addr;
                    wen_q        <= ls_wen;
                    wdata_q      <= ls_wdata;
                    wmask_q      <= ls_wmask;
                    if (!(&ls_cnt_q)) ls_cnt_q <= ls_cnt_q + CNT_W'(1);
                end else begin
                    // Fetches are always reads with no byte lanes enabled.
                    owner_q      <= REQ_IF;
                    last_grant_q <= REQ_IF;
                    addr_q       <= if_addr;
                    wen_q        <= 1'b0;
                    wdata_q      <= '0;
                    wmask_q      <= '0;
                    if (!(&if_cnt_q)) if_cnt_q <= if_cnt_q + CNT_W'(1);
                end
            end

            if (mem_resp_valid && (state_q != WAIT)) err_q <= 1'b1;

            if (if_resp_valid) if_rdata_q <= mem_rdata;
            if (ls_resp_valid) ls_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: a per-cycle vector table for the single
// IFU read and the stalled LSU write, plus hand-written sequences for reset,
// arbitration, spurious responses, mid-transaction reset and counter
// saturation (second instance with CNT_W = 2).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [63:0] if_addr, if_rdata;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        busy, err_spurious;
    logic [31:0] if_grant_cnt, ls_grant_cnt;

    logic        s_if_req_ready, s_if_resp_valid, s_ls_req_ready, s_ls_resp_valid;
    logic [63:0] s_if_rdata, s_ls_rdata, s_mem_addr, s_mem_wdata;
    logic        s_mem_req_valid, s_mem_wen, s_busy, s_err;
    logic [7:0]  s_mem_wmask;
    logic [1:0]  s_if_cnt, s_ls_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .err_spurious(err_spurious),
        .if_grant_cnt(if_grant_cnt), .ls_grant_cnt(ls_grant_cnt)
    );

    mem_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(s_if_req_ready), .if_addr(if_addr),
        .if_resp_valid(s_if_resp_valid), .if_rdata(s_if_rdata),
        .ls_req_valid(1'b0), .ls_req_ready(s_ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(s_ls_resp_valid), .ls_rdata(s_ls_rdata),
        .mem_req_valid(s_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(s_mem_addr),
        .mem_wen(s_mem_wen), .mem_wdata(s_mem_wdata), .mem_wmask(s_mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(s_busy), .err_spurious(s_err),
        .if_grant_cnt(s_if_cnt), .ls_grant_cnt(s_ls_cnt)
    );

    typedef struct {
        logic        if_v;
        logic [63:0] if_a;
        logic        ls_v;
        logic [63:0] ls_a;
        logic        ls_w;
        logic [63:0] ls_d;
        logic [7:0]  ls_m;
        logic        mrdy;
        logic        mrsp;
        logic [63:0] mrd;
        logic        e_ifr;
        logic        e_lsr;
        logic        e_mv;
        logic [63:0] e_ma;
        logic        e_mw;
        logic [63:0] e_md;
        logic [7:0]  e_mm;
        logic        e_ifv;
        logic        e_lsv;
        logic        chk_rd;
        logic [63:0] e_rd;
        logic        e_busy;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req_valid   = 1'b0;
        if_addr        = '0;
        ls_req_valid   = 1'b0;
        ls_addr        = '0;
        ls_wen         = 1'b0;
        ls_wdata       = '0;
        ls_wmask       = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    // Plain IFU read with a zero-wait memory: grant, REQ, WAIT+response.
    task automatic ifu_txn(input logic [63:0] a, input logic [63:0] d);
        if_req_valid = 1'b1; if_addr = a; mem_req_ready = 1'b1;
        next_cycle();
        if_req_valid = 1'b0;
        next_cycle();
        mem_resp_valid = 1'b1; mem_rdata = d;
        @(negedge clk);
        chk("ifu_txn_rdata", if_rdata, d);
        next_cycle();
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        logic exp_ls;

        // Single IFU read; ls_wen/ls_wmask are set but must not leak into the fetch.
        vt[0]  = '{1'b1, 64'h8000_0000, 1'b0, 64'h0, 1'b1, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0,
                   1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
        vt[1]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b1, 1'b0, 64'h0,
                   1'b0, 1'b0, 1'b1, 64'h8000_0000, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1};
        vt[2]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b1, 64'h0010_0073,
                   1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1, 64'h0010_0073, 1'b1};
        vt[3]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0,
                   1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
        // LSU write, memory stalls 3 cycles; request fields drop after the grant.
        vt[4]  = '{1'b0, 64'h0, 1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1'b0, 1'b0, 64'h0,
                   1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
        for (int i = 5; i < 8; i++)
            vt[i] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0,
                      1'b0, 1'b0, 1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1};
        vt[8]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b1, 1'b0, 64'h0,
                   1'b0, 1'b0, 1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1};
        vt[9]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b1, 64'h55,
                   1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1};
        vt[10] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0,
                   1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};

        // Reset state, with both requests raised while reset is held.
        idle_inputs();
        rst_n = 1'b0;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_ready", if_req_ready, 0);
        chk("rst_ls_ready", ls_req_ready, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_spurious, 0);
        chk("rst_if_cnt", if_grant_cnt, 0);
        chk("rst_ls_cnt", ls_grant_cnt, 0);
        chk("rst_mem_addr", mem_addr, 0);
        do_reset();

        // Vector table.
        for (int i = 0; i < 11; i++) begin
            if_req_valid   = vt[i].if_v;  if_addr  = vt[i].if_a;
            ls_req_valid   = vt[i].ls_v;  ls_addr  = vt[i].ls_a;
            ls_wen         = vt[i].ls_w;  ls_wdata = vt[i].ls_d;  ls_wmask = vt[i].ls_m;
            mem_req_ready  = vt[i].mrdy;
            mem_resp_valid = vt[i].mrsp;  mem_rdata = vt[i].mrd;
            @(negedge clk);
            chk($sformatf("v%0d_if_ready", i), if_req_ready, vt[i].e_ifr);
            chk($sformatf("v%0d_ls_ready", i), ls_req_ready, vt[i].e_lsr);
            chk($sformatf("v%0d_mem_valid", i), mem_req_valid, vt[i].e_mv);
            chk($sformatf("v%0d_if_resp", i), if_resp_valid, vt[i].e_ifv);
            chk($sformatf("v%0d_ls_resp", i), ls_resp_valid, vt[i].e_lsv);
            chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
            if (vt[i].e_mv) begin
                chk($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].e_ma);
                chk($sformatf("v%0d_mem_wen", i), mem_wen, vt[i].e_mw);
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vt[i].e_md);
                chk($sformatf("v%0d_mem_wmask", i), mem_wmask, vt[i].e_mm);
            end
            if (vt[i].chk_rd) chk($sformatf("v%0d_if_rdata", i), if_rdata, vt[i].e_rd);
            next_cycle();
            if (i == 3) chk("if_cnt_after_read", if_grant_cnt, 1);
        end
        chk("ls_cnt_after_write", ls_grant_cnt, 1);
        chk("if_cnt_after_write", if_grant_cnt, 1);

        // Both requesters valid for 4 transactions.
        do_reset();
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_ls = (k % 2 == 0);
`else
            exp_ls = 1'b1;
`endif
            if_req_valid = 1'b1; if_addr = 64'h1000 + 64'(k * 8);
            ls_req_valid = 1'b1; ls_addr = 64'h2000 + 64'(k * 8); ls_wen = 1'b0;
            mem_req_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("both%0d_if_ready", k), if_req_ready, !exp_ls);
            chk($sformatf("both%0d_ls_ready", k), ls_req_ready, exp_ls);
            next_cycle();
            @(negedge clk);
            chk($sformatf("both%0d_mem_addr", k), mem_addr,
                exp_ls ? 64'h2000 + 64'(k * 8) : 64'h1000 + 64'(k * 8));
            next_cycle();
            mem_resp_valid = 1'b1; mem_rdata = 64'hA0 + 64'(k);
            @(negedge clk);
            chk($sformatf("both%0d_if_resp", k), if_resp_valid, !exp_ls);
            chk($sformatf("both%0d_ls_resp", k), ls_resp_valid, exp_ls);
            chk($sformatf("both%0d_rdata", k), exp_ls ? ls_rdata : if_rdata, 64'hA0 + 64'(k));
            next_cycle();
            mem_resp_valid = 1'b0;
        end
`ifdef MEM_ARB_RR_EN
        chk("both_ls_cnt", ls_grant_cnt, 2);
        chk("both_if_cnt", if_grant_cnt, 2);
`else
        chk("both_ls_cnt", ls_grant_cnt, 4);
        chk("both_if_cnt", if_grant_cnt, 0);
`endif
        idle_inputs();
        next_cycle();

        // Spurious response in IDLE.
        mem_resp_valid = 1'b1; mem_rdata = 64'h77;
        @(negedge clk);
        chk("spur_if_resp", if_resp_valid, 0);
        chk("spur_ls_resp", ls_resp_valid, 0);
        next_cycle();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("spur_err_set", err_spurious, 1);
        next_cycle();
        @(negedge clk);
        chk("spur_err_sticky", err_spurious, 1);
        next_cycle();

        // Reset during WAIT.
        if_req_valid = 1'b1; if_addr = 64'h3000; mem_req_ready = 1'b1;
        next_cycle();
        if_req_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("wait_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err_spurious, 0);
        chk("midrst_if_cnt", if_grant_cnt, 0);
        chk("midrst_ls_cnt", ls_grant_cnt, 0);
        chk("midrst_mem_valid", mem_req_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        mem_resp_valid = 1'b1; mem_rdata = 64'h99;
        @(negedge clk);
        chk("postrst_no_if_resp", if_resp_valid, 0);
        next_cycle();
        mem_resp_valid = 1'b0;

        // Counter saturation (second instance has CNT_W = 2).
        do_reset();
        for (int k = 0; k < 5; k++) ifu_txn(64'h4000 + 64'(k * 4), 64'hC0 + 64'(k));
        @(negedge clk);
        chk("sat_if_cnt", s_if_cnt, 3);
        chk("sat_ls_cnt", s_ls_cnt, 0);
        chk("wide_if_cnt", if_grant_cnt, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Accepts one request at a time, latches it and drives it to memory with a valid/ready handshake, then routes the response back to the owner.
- Sits between the PC/fetch logic, the LSU and the memory model (DPI vmem read/write wrapper).
- At most one transaction is outstanding.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; DATA_W/8 gives the wmask width.
- CNT_W, 32, width of the saturating per-requester grant counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- if_req_valid  in  1  IFU read request.
- if_req_ready  out  1  IFU request accepted this cycle.
- if_addr  in  ADDR_W  IFU fetch address.
- if_resp_valid  out  1  IFU read data valid.
- if_rdata  out  DATA_W  IFU read data.
- ls_req_valid  in  1  LSU request.
- ls_req_ready  out  1  LSU request accepted this cycle.
- ls_addr  in  ADDR_W  LSU address.
- ls_wen  in  1  1 = write, 0 = read.
- ls_wdata  in  DATA_W  write data.
- ls_wmask  in  DATA_W/8  byte write mask.
- ls_resp_valid  out  1  LSU read data or write acknowledge.
- ls_rdata  out  DATA_W  LSU read data; don't-care for writes.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_W  latched address.
- mem_wen  out  1  latched write enable.
- mem_wdata  out  DATA_W  latched write data.
- mem_wmask  out  DATA_W/8  latched byte mask.
- mem_resp_valid  in  1  memory response (read data or write acknowledge).
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  1 whenever state != IDLE.
- err_spurious  out  1  sticky flag: mem_resp_valid seen outside WAIT.
- if_grant_cnt  out  CNT_W  number of IFU grants, saturating.
- ls_grant_cnt  out  CNT_W  number of LSU grants, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; owner = IFU; last_grant = IFU.
  - All latched request registers = 0; counters = 0; err_spurious = 0.
  - All valid/ready outputs = 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If any *_req_valid is high, grant exactly one requester.
  - Grant = combinational *_req_ready = 1 in the same cycle.
  - At the clock edge: latch addr/wen/wdata/wmask and owner, increment the owner's counter, go to REQ.
  - For an IFU grant, the latched wen = 0 and wmask = 0.
  - If no request is valid, stay in IDLE with both ready outputs = 0.
- REQ:
  - mem_req_valid = 1; mem_* are driven only from the latched registers.
  - If mem_req_ready = 1, go to WAIT; otherwise hold. Latched values stay stable while waiting.
- WAIT:
  - When mem_resp_valid = 1, the owner's *_resp_valid = 1 combinationally and *_rdata = mem_rdata in the same cycle; go to IDLE.
  - The non-owner's resp_valid stays 0.
- Latency:
  - Grant to mem_req_valid is 1 cycle.
  - A response passes through with 0 added cycles.
  - With zero-wait memory, each transaction takes 3 cycles; back-to-back requests are granted again in the IDLE cycle that follows.
- Arbitration (default, fixed priority):
  - LSU wins over IFU when both are valid.
  - last_grant is updated on every grant.
- Requesters must hold request fields until ready is asserted. Fields are sampled only in the grant cycle.
- Spurious response: mem_resp_valid in IDLE or REQ is ignored (no resp_valid to any requester) and sets err_spurious. err_spurious clears only on reset.
- Counters saturate at all-ones and do not wrap.
- *_rdata is held at the last mem_rdata routed to that requester; it is don't-care when resp_valid = 0.
- Reset asserted mid-transaction aborts the transaction immediately; no response is delivered after reset is released.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On a conflict, the requester that is not last_grant wins. With both requesters valid continuously, grants alternate LSU, IFU, LSU, … (the first conflict after reset goes to LSU because last_grant resets to IFU).
- Undefined: fixed LSU priority as described above; last_grant is still tracked but unused.

Decomposition:
- Shared package mem_arb_pkg:
  - State enum (IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2).
  - Requester ID constants (REQ_IF = 1'b0, REQ_LS = 1'b1).
  - Default width constants.
- One natural sub-module: arb_pick.
  - Combinational 2-way picker taking valids and last_grant, producing a one-hot grant.
  - Contains the MEM_ARB_RR_EN switch.
- FSM, latches and counters stay in mem_arbiter.

Test Plan:
- Single IFU read:
  - Stimulus: if_addr = 0x80000000, memory ready at once, response 1 cycle later with rdata = 0x00100073.
  - Required: if_req_ready in cycle 0; mem_req_valid with mem_addr = 0x80000000, mem_wen = 0 in cycle 1; if_resp_valid with if_rdata = 0x00100073 in cycle 2; if_grant_cnt = 1.
- LSU write with stalled memory:
  - Stimulus: ls_addr = 0x80001000, wdata = 0xDEADBEEF, wmask = 0x0F; mem_req_ready low for 3 cycles.
  - Required: mem_* stable for all 4 REQ cycles; ls_resp_valid on the acknowledge; if_resp_valid never asserted.
- Simultaneous requests, macro undefined:
  - Stimulus: both requesters valid for 4 transactions.
  - Required: LSU granted all 4 times; ls_grant_cnt = 4, if_grant_cnt = 0.
- Simultaneous requests, MEM_ARB_RR_EN defined:
  - Stimulus: same as above.
  - Required: grant order LSU, IFU, LSU, IFU; both counters = 2.
- Spurious response and reset:
  - Stimulus: mem_resp_valid pulsed in IDLE.
  - Required: err_spurious = 1 and no resp_valid to either requester.
  - Stimulus: rst_n pulsed low during WAIT.
  - Required: state = IDLE, busy = 0, err_spurious = 0, counters = 0.
- Counter saturation:
  - Stimulus: CNT_W = 2, 5 IFU grants.
  - Required: if_grant_cnt = 3.
